// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from several requesters into a single uart_tx.
// A packet (bytes up to and including the one flagged last) holds the grant until it completes.
module uart_tx_arbiter #(
   parameter int NumReq      = 3,
   parameter int BusyTimeout = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NumReq-1:0]     i_req_valid,
   input  logic [8*NumReq-1:0]   i_req_data,
   input  logic [NumReq-1:0]     i_req_last,
   output logic [NumReq-1:0]     o_req_ready,
   output logic                  o_tx_enable,
   output logic [7:0]            o_tx_data,
   input  logic                  i_tx_busy,
   output logic [NumReq-1:0]     o_grant,
   output logic                  o_timeout
);

   localparam int IdxW = $clog2(NumReq);
   localparam int PosW = IdxW + 1;
   localparam int CntW = $clog2(BusyTimeout + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              locked;
   logic [IdxW-1:0]   lock_owner;
   logic [IdxW-1:0]   last_winner;
   logic [IdxW-1:0]   cand;
   logic              cand_found;
   logic [PosW-1:0]   scan_pos;
   logic              handshake;
   logic              busy_expired;
   logic [CntW-1:0]   busy_cnt;
   logic [7:0]        req_bytes [NumReq];

   always_comb begin
      for (int k = 0; k < NumReq; k++) begin
         req_bytes[k] = i_req_data[8*k +: 8];
      end
   end

   // A locked packet owner is the only candidate; otherwise scan upward from the requester after the last winner.
   always_comb begin
      cand       = '0;
      cand_found = 1'b0;
      scan_pos   = '0;
      if (locked) begin
         cand       = lock_owner;
         cand_found = i_req_valid[lock_owner];
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            scan_pos = {1'b0, last_winner} + PosW'(i + 1);
            if (scan_pos >= PosW'(NumReq)) begin
               scan_pos = scan_pos - PosW'(NumReq);
            end
            if (!cand_found && i_req_valid[scan_pos[IdxW-1:0]]) begin
               cand_found = 1'b1;
               cand       = scan_pos[IdxW-1:0];
            end
         end
      end
   end

   assign handshake    = (state == IDLE) && !i_tx_busy && cand_found;
   assign busy_expired = (state == WAIT_BUSY) && !i_tx_busy &&
                         (busy_cnt == CntW'(BusyTimeout - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (handshake) state_next = ISSUE;
         end
         ISSUE: begin
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (i_tx_busy)         state_next = WAIT_DONE;
            else if (busy_expired) state_next = IDLE;
         end
         WAIT_DONE: begin
            if (!i_tx_busy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_tx_enable = (state == ISSUE);
      o_req_ready = '0;
      if (handshake) begin
         o_req_ready[cand] = 1'b1;
      end
   end

   // The grant is kept across a packet so the owner stays visible while the lock stalls the arbiter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         locked      <= 1'b0;
         lock_owner  <= '0;
         last_winner <= IdxW'(NumReq - 1);
         o_tx_data   <= '0;
         o_grant     <= '0;
         o_timeout   <= 1'b0;
         busy_cnt    <= '0;
      end else begin
         o_timeout <= busy_expired;
         if (state == ISSUE) begin
            busy_cnt <= '0;
         end else if (state == WAIT_BUSY) begin
            busy_cnt <= busy_cnt + CntW'(1);
         end
         if (handshake) begin
            o_tx_data <= req_bytes[cand];
            o_grant   <= o_req_ready;
            if (i_req_last[cand]) begin
               locked      <= 1'b0;
               last_winner <= cand;
            end else begin
               locked     <= 1'b1;
               lock_owner <= cand;
            end
         end else if ((state != IDLE) && (state_next == IDLE) && !locked) begin
            o_grant <= '0;
         end
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 3, number of byte requesters (2..8).
REQ-002 SHALL have parameter BusyTimeout, default 8, max cycles to wait for i_tx_busy rise after a launch.
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  NumReq  per-requester byte valid.
REQ-006 SHALL have port i_req_data  input  8*NumReq  per-requester byte; requester k in bits [8k+7:8k].
REQ-007 SHALL have port i_req_last  input  NumReq  byte is final byte of requester packet.
REQ-008 SHALL have port o_req_ready  output  NumReq  byte accepted when valid&ready in same cycle.
REQ-009 SHALL have port o_tx_enable  output  1  one-cycle launch strobe to uart_tx.
REQ-010 SHALL have port o_tx_data  output  8  byte to uart_tx, stable from launch until return to IDLE.
REQ-011 SHALL have port i_tx_busy  input  1  uart_tx busy flag.
REQ-012 SHALL have port o_grant  output  NumReq  one-hot owner of current byte/packet, zero when idle and unlocked.
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse when BusyTimeout expires.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 In IDLE with i_tx_busy=0: if locked, candidate = lock owner only; else candidate = first requester with valid=1 scanning from (last_winner+1) mod NumReq upward, wrapping.
REQ-016 o_req_ready SHALL be combinational: bit k high only in IDLE, i_tx_busy=0, k = candidate, i_req_valid[k]=1; all other bits 0.
REQ-017 On handshake: capture byte into o_tx_data, set o_grant one-hot k, go to ISSUE next cycle.
REQ-018 ISSUE: o_tx_enable=1 for exactly that cycle; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: on i_tx_busy=1 go to WAIT_DONE; if BusyTimeout cycles elapse without it, pulse o_timeout and go to IDLE.
REQ-020 WAIT_DONE: on i_tx_busy=0 go to IDLE; no timeout.
REQ-021 Accepted byte with last=0 SHALL lock arbitration to k; last=1 SHALL clear lock and set last_winner=k.
REQ-022 While locked and owner valid=0, arbiter SHALL stall in IDLE, serving no other requester; o_grant stays on owner.
REQ-023 Unlocked in IDLE, o_grant SHALL be 0 after the byte completes.
REQ-024 Minimum byte period SHALL be launch + 1 + uart_tx busy time; no back-to-back o_tx_enable without intervening busy fall or timeout.
REQ-025 i_tx_busy=1 in IDLE SHALL block all grants until low.
REQ-026 Simultaneous valid on several requesters SHALL grant exactly one per handshake; rotation guarantees each valid requester service within NumReq packets.
REQ-027 Changes of i_req_data after handshake SHALL not affect o_tx_data.

Reset
REQ-028 i_rst=1 SHALL immediately force state IDLE, lock cleared, last_winner=NumReq-1 (so requester 0 has first priority), o_tx_data=0, o_grant=0, o_tx_enable=0, o_timeout=0, timeout counter=0.
REQ-029 Reset mid-byte SHALL abandon the byte; no o_tx_enable after release until a new handshake.

Verification
REQ-030 Single byte: req0 valid, data 0x41, last=1, busy model rises 1 cycle after enable, holds 10 cycles -> ready0 one cycle, enable one cycle with o_tx_data=0x41, back in IDLE, o_grant=0.
REQ-031 Round-robin: req0,req1,req2 all valid with last=1 continuously -> service order 0,1,2,0,1,2 over six bytes.
REQ-032 Packet lock: req1 sends 0x10,0x11,0x12 (last on 0x12) while req0 and req2 valid -> three req1 bytes consecutive, then req2, then req0.
REQ-033 Lock stall: req0 sends 0x20 last=0 then drops valid 20 cycles while req1 valid -> no req1 grant until req0 sends 0x21 last=1.
REQ-034 Timeout: busy held 0 after enable -> o_timeout pulse exactly 8 cycles after WAIT_BUSY entry, FSM to IDLE, next byte served.
REQ-035 Reset mid-WAIT_DONE: assert i_rst during busy -> all outputs 0 immediately, req0 first priority after release.
